// File: rtl/f1_pkg.sv
// Shared types and default parameter values for the F1 start-light sequencer.
// The FAULT state exists only when F1_JUMPSTART_EN is defined.
package f1_pkg;

    localparam int N_LEDS_DEF   = 10;
    localparam int STEP_DEF     = 2;
    localparam int GO_TICKS_DEF = 3;

`ifdef F1_JUMPSTART_EN
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DELAY,
        GO,
        FAULT
    } f1_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DELAY,
        GO
    } f1_state_t;
`endif

endpackage

// File: rtl/f1_light_bar.sv
// Maps a lit-light count onto an MSB-first thermometer pattern for the light bar.
module f1_light_bar
    import f1_pkg::*;
#(
    parameter int N_LEDS = N_LEDS_DEF
) (
    input  logic [$clog2(N_LEDS+1)-1:0] lit,
    output logic [N_LEDS-1:0]           pattern
);

    always_comb begin
        pattern = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            pattern[N_LEDS-1-i] = (i < int'(lit));
        end
    end

endmodule

// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: lights fill per tick, wait for the random delay, then go.
// Define F1_JUMPSTART_EN to add false-start detection (react input, FAULT state).
module f1_start_seq
    import f1_pkg::*;
#(
    parameter int N_LEDS   = N_LEDS_DEF,
    parameter int STEP     = STEP_DEF,
    parameter int GO_TICKS = GO_TICKS_DEF
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              trigger,
    input  logic              time_out,
    input  logic              abort,
    input  logic              react,
    output logic              en_lfsr,
    output logic              start_delay,
    output logic [N_LEDS-1:0] ledr,
    output logic              go,
    output logic              busy,
    output logic              jump_start
);

    localparam int              LW      = $clog2(N_LEDS + 1);
    localparam logic [LW:0]     STEP_W  = (LW+1)'(STEP);
    localparam logic [LW:0]     FULL_W  = (LW+1)'(N_LEDS);
    localparam logic [LW-1:0]   FULL    = LW'(N_LEDS);
    localparam logic [7:0]      GO_LAST = 8'(GO_TICKS - 1);

    f1_state_t         state_q, state_d;
    logic [LW-1:0]     lit_q, lit_d;
    logic [LW:0]       lit_sum;
    logic [7:0]        go_cnt_q, go_cnt_d;
    logic [N_LEDS-1:0] ledr_q, ledr_d;
    logic [N_LEDS-1:0] bar_pattern;
    logic              en_lfsr_q, en_lfsr_d;
    logic              start_delay_q, start_delay_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;

    f1_light_bar #(.N_LEDS(N_LEDS)) u_light_bar (
        .lit     (lit_d),
        .pattern (bar_pattern)
    );

    always_comb begin
        state_d  = state_q;
        lit_d    = lit_q;
        go_cnt_d = go_cnt_q;
        // One extra bit so lit+STEP can exceed N_LEDS before clamping.
        lit_sum  = {1'b0, lit_q} + STEP_W;

        unique case (state_q)
            IDLE: begin
                go_cnt_d = '0;
                if (trigger) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
`ifdef F1_JUMPSTART_EN
                end else if (react) begin
                    state_d = FAULT;
`endif
                end else if (tick) begin
                    if (lit_sum >= FULL_W) begin
                        lit_d   = FULL;
                        state_d = DELAY;
                    end else begin
                        lit_d   = lit_sum[LW-1:0];
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
`ifdef F1_JUMPSTART_EN
                end else if (react) begin
                    state_d = FAULT;
`endif
                end else if (time_out) begin
                    state_d  = GO;
                    go_cnt_d = '0;
                end
            end
            GO: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (go_cnt_q == GO_LAST) begin
                        state_d = IDLE;
                    end else begin
                        go_cnt_d = go_cnt_q + 8'd1;
                    end
                end
            end
`ifdef F1_JUMPSTART_EN
            FAULT: begin
                if (trigger || abort) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Only COUNT and DELAY keep lights counted; every other state starts from dark.
        if (state_d != COUNT && state_d != DELAY) begin
            lit_d = '0;
        end

        ledr_d = bar_pattern;
`ifdef F1_JUMPSTART_EN
        if (state_d == FAULT) begin
            if (state_q != FAULT) begin
                ledr_d = '1;
            end else if (tick) begin
                ledr_d = ~ledr_q;
            end else begin
                ledr_d = ledr_q;
            end
        end
`endif

        busy_d        = (state_d != IDLE);
        go_d          = (state_d == GO);
        start_delay_d = (state_d == DELAY);
        en_lfsr_d     = (state_d != DELAY);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lit_q         <= '0;
            go_cnt_q      <= '0;
            ledr_q        <= '0;
            en_lfsr_q     <= 1'b0;
            start_delay_q <= 1'b0;
            go_q          <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lit_q         <= lit_d;
            go_cnt_q      <= go_cnt_d;
            ledr_q        <= ledr_d;
            en_lfsr_q     <= en_lfsr_d;
            start_delay_q <= start_delay_d;
            go_q          <= go_d;
            busy_q        <= busy_d;
        end
    end

`ifdef F1_JUMPSTART_EN
    logic jump_start_q, jump_start_d;

    assign jump_start_d = (state_d == FAULT);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            jump_start_q <= 1'b0;
        end else begin
            jump_start_q <= jump_start_d;
        end
    end

    assign jump_start = jump_start_q;
`else
    logic unused_react;
    assign unused_react = react;
    assign jump_start   = 1'b0;
`endif

    assign en_lfsr     = en_lfsr_q;
    assign start_delay = start_delay_q;
    assign ledr        = ledr_q;
    assign go          = go_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_f1_start_seq.sv
// Self-checking bench for f1_start_seq: two instances (STEP=2 and STEP=3) against a
// behavioural model, directed sequences followed by randomized stimulus.
module tb_f1_start_seq;

    localparam int N  = 10;
    localparam int GT = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_COUNT = 1;
    localparam int PH_DELAY = 2;
    localparam int PH_GO    = 3;
    localparam int PH_FAULT = 4;

    logic sysclk = 1'b0;
    logic rst_n = 1'b0, tick = 1'b0, trigger = 1'b0, time_out = 1'b0, abort = 1'b0, react = 1'b0;

    logic         en2, sd2, go2, busy2, js2;
    logic [N-1:0] ledr2;
    logic         en3, sd3, go3, busy3, js3;
    logic [N-1:0] ledr3;

    always #5 sysclk = ~sysclk;

    f1_start_seq #(.N_LEDS(N), .STEP(2), .GO_TICKS(GT)) dut2 (
        .sysclk(sysclk), .rst_n(rst_n), .tick(tick), .trigger(trigger),
        .time_out(time_out), .abort(abort), .react(react),
        .en_lfsr(en2), .start_delay(sd2), .ledr(ledr2), .go(go2),
        .busy(busy2), .jump_start(js2)
    );

    f1_start_seq #(.N_LEDS(N), .STEP(3), .GO_TICKS(GT)) dut3 (
        .sysclk(sysclk), .rst_n(rst_n), .tick(tick), .trigger(trigger),
        .time_out(time_out), .abort(abort), .react(react),
        .en_lfsr(en3), .start_delay(sd3), .ledr(ledr3), .go(go3),
        .busy(busy3), .jump_start(js3)
    );

    int total = 0;
    int bad   = 0;

    int m_ph[2];
    int m_lit[2];
    int m_goc[2];
    bit m_on[2];
    bit m_fresh;
    int stp[2] = '{2, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] therm(input int lit);
        int v;
        v = ((1 << lit) - 1) << (N - lit);
        return 32'(v);
    endfunction

    // {jump_start, en_lfsr, start_delay, busy, go, ledr[9:0]}
    function automatic logic [31:0] model_pack(input int k);
        logic [31:0] led;
        bit gv, bv, sv, ev, jv;
        led = 32'h0;
        case (m_ph[k])
            PH_COUNT: led = therm(m_lit[k]);
            PH_DELAY: led = therm(N);
            PH_FAULT: led = m_on[k] ? therm(N) : 32'h0;
            default:  led = 32'h0;
        endcase
        gv = (m_ph[k] == PH_GO);
        bv = (m_ph[k] != PH_IDLE);
        sv = (m_ph[k] == PH_DELAY);
        ev = !m_fresh && (m_ph[k] != PH_DELAY);
        jv = (m_ph[k] == PH_FAULT);
        return led | (32'(gv) << 10) | (32'(bv) << 11) | (32'(sv) << 12)
                   | (32'(ev) << 13) | (32'(jv) << 14);
    endfunction

    function automatic logic [31:0] dut_pack(input int k);
        if (k == 0) return {17'b0, js2, en2, sd2, busy2, go2, ledr2};
        return {17'b0, js3, en3, sd3, busy3, go3, ledr3};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = PH_IDLE; m_lit[k] = 0; m_goc[k] = 0; m_on[k] = 1'b0;
        end
        m_fresh = 1'b1;
    endtask

    task automatic model_step(input bit tk, input bit tr, input bit to, input bit ab, input bit rc);
        bit jump_en;
`ifdef F1_JUMPSTART_EN
        jump_en = 1'b1;
`else
        jump_en = 1'b0;
`endif
        m_fresh = 1'b0;
        for (int k = 0; k < 2; k++) begin
            case (m_ph[k])
                PH_IDLE: if (tr) begin m_ph[k] = PH_COUNT; m_lit[k] = 0; end
                PH_COUNT: begin
                    if (ab) m_ph[k] = PH_IDLE;
                    else if (rc && jump_en) begin m_ph[k] = PH_FAULT; m_on[k] = 1'b1; end
                    else if (tk) begin
                        m_lit[k] = (m_lit[k] + stp[k] > N) ? N : m_lit[k] + stp[k];
                        if (m_lit[k] == N) m_ph[k] = PH_DELAY;
                    end
                end
                PH_DELAY: begin
                    if (ab) m_ph[k] = PH_IDLE;
                    else if (rc && jump_en) begin m_ph[k] = PH_FAULT; m_on[k] = 1'b1; end
                    else if (to) begin m_ph[k] = PH_GO; m_goc[k] = 0; end
                end
                PH_GO: begin
                    if (ab) m_ph[k] = PH_IDLE;
                    else if (tk) begin
                        m_goc[k]++;
                        if (m_goc[k] == GT) m_ph[k] = PH_IDLE;
                    end
                end
                PH_FAULT: begin
                    if (tr || ab) m_ph[k] = PH_IDLE;
                    else if (tk) m_on[k] = !m_on[k];
                end
                default: m_ph[k] = PH_IDLE;
            endcase
        end
    endtask

    // Drive inputs after the falling edge, step the model on the rising edge, check 1 ns later.
    task automatic cyc(input bit tk, input bit tr, input bit to, input bit ab, input bit rc);
        tick = tk; trigger = tr; time_out = to; abort = ab; react = rc;
        @(posedge sysclk);
        model_step(tk, tr, to, ab, rc);
        #1;
        chk("s2_outputs", dut_pack(0), model_pack(0));
        chk("s3_outputs", dut_pack(1), model_pack(1));
        @(negedge sysclk);
    endtask

    task automatic do_reset();
        tick = 0; trigger = 0; time_out = 0; abort = 0; react = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("s2_reset", dut_pack(0), model_pack(0));
        chk("s3_reset", dut_pack(1), model_pack(1));
        chk("reset_zero", {dut_pack(0), dut_pack(1)} == 64'h0, 1'b1);
        rst_n = 1'b1;
    endtask

    logic [31:0] e2[5] = '{32'h300, 32'h3C0, 32'h3F0, 32'h3FC, 32'h3FF};
    logic [31:0] e3[5] = '{32'h380, 32'h3F0, 32'h3FE, 32'h3FF, 32'h3FF};

    initial begin
        @(negedge sysclk);
        do_reset();
        cyc(0, 0, 0, 0, 0);
        chk("en_after_release", en2, 1'b1);

        // Fill sequence for both step sizes
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("fill_s2", 32'(ledr2), e2[i]);
            chk("fill_s3", 32'(ledr3), e3[i]);
        end
        chk("delay_sd", {sd2, sd3, en2, en3}, 4'b1100);

        // time_out with tick in DELAY, then GO held for GT ticks
        cyc(1, 0, 1, 0, 0);
        chk("go_on", {go2, go3, 8'(ledr2), 8'(ledr3)}, {2'b11, 16'h0});
        for (int i = 0; i < GT; i++) cyc(1, 0, 0, 0, 0);
        chk("go_done", {go2, busy2, go3, busy3}, 4'b0000);

        // Abort mid-count; later time_out ignored
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pre_abort", 32'(ledr2), 32'h3C0);
        cyc(0, 0, 0, 1, 0);
        chk("abort_idle", {busy2, 10'(ledr2)}, 11'h0);
        cyc(0, 0, 1, 0, 0);
        chk("to_ignored", {busy2, go2, sd2}, 3'b000);

        // Asynchronous reset mid-COUNT
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        #2;
        do_reset();
        cyc(0, 0, 0, 0, 0);
        chk("en_rel_again", {en2, busy2}, 2'b10);

`ifdef F1_JUMPSTART_EN
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("js_set", {js2, 10'(ledr2)}, 11'h7FF);
        cyc(1, 0, 0, 0, 0);
        chk("js_off", {js2, 10'(ledr2)}, 11'h400);
        cyc(1, 0, 0, 0, 0);
        chk("js_on", 32'(ledr2), 32'h3FF);
        cyc(0, 1, 0, 0, 0);
        chk("js_clear", {js2, busy2}, 2'b00);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 29) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
